// File: rtl/fx_pkg.sv
// Shared types for the matrix rain effect: run modes and controller states.
package fx_pkg;

  typedef enum logic [1:0] {
    RAIN  = 2'b00,
    FILL  = 2'b01,
    DRAIN = 2'b10,
    RSVD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, XNOR feedback from taps 16,15,13,4.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'h0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  // XNOR feedback locks up only at all-ones, which the seed never reaches.
  always_comb begin
    value_d = {value_q[14:0], ~(value_q[15] ^ value_q[14] ^ value_q[12] ^ value_q[3])};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) value_q <= SEED;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/matrix_rain_fx.sv
// Falling-pixel display effect: a pattern shifts down one row per animation step,
// with the top row spawned from an LFSR according to the latched run mode.
module matrix_rain_fx
  import fx_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int TICK_MAX    = 300,
  parameter int RAIN_FRAMES = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 mode,
  output logic                       busy,
  output logic                       done,
  output logic [ROWS-1:0][COLS-1:0]  pattern
);

  localparam int CW = $clog2(TICK_MAX);
  localparam int FW = $clog2(RAIN_FRAMES + 1);
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_MAX - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(RAIN_FRAMES - 1);

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [FW-1:0]   frame_q, frame_d;
  frame_t          pattern_q, pattern_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [15:0]     lfsr;
  logic [COLS-1:0] spawn;
  logic            accept, shift, finished;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .value (lfsr)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    spawn = '0;
    for (int c = 0; c < COLS; c++) begin
      case (mode_q)
        RAIN:    spawn[c] = lfsr[c] & lfsr[(c + 5) % 16];
        FILL:    spawn[c] = lfsr[c] | pattern_q[0][c];
        default: spawn[c] = 1'b0;
      endcase
    end
  end

  always_comb begin
    accept    = (state_q == IDLE) && start && (mode != RSVD);
    shift     = (state_q == RUN) && (tick_q == TICK_LAST);
    pattern_d = shift ? {pattern_q[ROWS-2:0], spawn} : pattern_q;

    // Completion looks at the post-shift frame and is only honoured on a shift edge.
    case (mode_q)
      RAIN:    finished = (frame_q == FRAME_LAST);
      FILL:    finished = &pattern_d;
      default: finished = ~|pattern_d;
    endcase

    state_d = state_q;
    mode_d  = mode_q;
    tick_d  = tick_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          mode_d  = mode_t'(mode);
          tick_d  = '0;
          frame_d = '0;
        end
      end
      RUN: begin
        tick_d = shift ? '0 : tick_q + CW'(1);
        if (shift) begin
          if (mode_q == RAIN) frame_d = frame_q + FW'(1);
          if (finished)       state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= RAIN;
      tick_q    <= '0;
      frame_q   <= '0;
      // NOTE: the frame store is a plain register bank, so it is cleared like any other state.
      pattern_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tick_q    <= tick_d;
      frame_q   <= frame_d;
      pattern_q <= pattern_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pattern = pattern_q;

endmodule

// File: tb/tb_matrix_rain_fx.sv
// Scoreboard bench for matrix_rain_fx: the driver queues expected done events,
// a monitor checks every cycle's shift/hold behaviour and pops on each done pulse.
module tb_matrix_rain_fx;
  import fx_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int TICK   = 4;
  localparam int FRAMES = 10;

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;
  typedef struct {
    int     done_edge;
    frame_t pat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       busy, done;
  frame_t     pattern;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference timeline and LFSR model, advanced on every rising edge.
  int          edge_cnt = 0;
  logic        rst_at_edge = 1'b0;
  logic [15:0] lfsr_m = 16'h0004;
  logic [15:0] lfsr_prev = 16'h0004;

  // What the driver expects of the current run.
  logic   run_on = 1'b0;
  int     run_start = 0;
  int     run_end = 0;
  mode_t  run_mode = RAIN;
  frame_t cur_pat = '0;

  // Monitor scratch.
  frame_t prev_pat = '0;
  logic   is_shift;
  logic   busy_exp;
  logic [COLS-1:0] spawn_exp;
  exp_t   got;

  always #5 clk = ~clk;

  matrix_rain_fx #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .TICK_MAX    (TICK),
    .RAIN_FRAMES (FRAMES)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .pattern (pattern)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], ~(v[15] ^ v[14] ^ v[12] ^ v[3])};
  endfunction

  function automatic logic [COLS-1:0] spawn_of(input mode_t m, input logic [15:0] l,
                                               input logic [COLS-1:0] row0);
    logic [COLS-1:0] s;
    s = '0;
    for (int c = 0; c < COLS; c++) begin
      case (m)
        RAIN:    s[c] = l[c] & l[(c + 5) % 16];
        FILL:    s[c] = l[c] | row0[c];
        default: s[c] = 1'b0;
      endcase
    end
    return s;
  endfunction

  // Forward-simulates a run from the LFSR value just before the start edge.
  function automatic int predict(input mode_t m, input frame_t p0, input logic [15:0] l0,
                                 output frame_t pf);
    frame_t      p;
    logic [15:0] l;
    p = p0;
    l = l0;
    for (int k = 1; k <= 200; k++) begin
      for (int t = 0; t < TICK; t++) l = lfsr_step(l);
      p = {p[ROWS-2:0], spawn_of(m, l, p[0])};
      if ((m == RAIN && k == FRAMES) || (m == FILL && &p) || (m == DRAIN && p == '0)) begin
        pf = p;
        return k;
      end
    end
    pf = p;
    return 200;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  always @(posedge clk) begin
    edge_cnt    <= edge_cnt + 1;
    rst_at_edge <= reset;
    lfsr_prev   <= lfsr_m;
    lfsr_m      <= reset ? 16'h0004 : lfsr_step(lfsr_m);
  end

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_at_edge) begin
      check("rst_pattern", 32'(pattern), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_done", 32'(done), 32'(0));
      check("rst_lfsr", 32'(dut.u_lfsr.value), 32'h0004);
    end else begin
      is_shift = run_on && (edge_cnt > run_start) && (edge_cnt <= run_end) &&
                 ((edge_cnt - run_start) % TICK == 0);
      if (is_shift) begin
        spawn_exp = spawn_of(run_mode, lfsr_prev, prev_pat[0]);
        check("shift_rows", 32'(pattern[ROWS-1:1]), 32'(prev_pat[ROWS-2:0]));
        check("spawn_row0", 32'(pattern[0]), 32'(spawn_exp));
        if (run_mode == FILL) check("fill_gain", 32'(pattern & prev_pat), 32'(prev_pat));
      end else begin
        check("hold", 32'(pattern), 32'(prev_pat));
      end
      busy_exp = run_on && (edge_cnt >= run_start) && (edge_cnt < run_end);
      check("busy", 32'(busy), 32'(busy_exp));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'(0));
        end else begin
          got = exp_q.pop_front();
          check("done_edge", 32'(edge_cnt), 32'(got.done_edge));
          check("done_pattern", 32'(pattern), 32'(got.pat));
        end
      end else if (run_on && edge_cnt == run_end) begin
        check("done_missing", 32'(done), 32'(1));
      end
    end
    prev_pat = pattern;
  end

  // hand_off > 0 gives a hand-computed done offset; otherwise the model predicts it.
  task automatic issue(input mode_t m, input int hand_off, input logic hand_pat_ok,
                       input frame_t hand_pat);
    exp_t   e;
    frame_t pf;
    int     ns;
    @(negedge clk);
    ns          = predict(m, cur_pat, lfsr_m, pf);
    e.done_edge = edge_cnt + 1 + ((hand_off > 0) ? hand_off : TICK * ns);
    e.pat       = hand_pat_ok ? hand_pat : pf;
    run_start   = edge_cnt + 1;
    run_end     = e.done_edge;
    run_mode    = m;
    run_on      = 1'b1;
    cur_pat     = e.pat;
    exp_q.push_back(e);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = RSVD;
  endtask

  task automatic wait_done();
    while (edge_cnt < run_end + 1) @(negedge clk);
    run_on = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // DRAIN on an empty frame finishes after one shift.
    issue(DRAIN, TICK, 1'b1, '0);
    wait_done();

    // FILL to all ones; completion edge comes from the model.
    issue(FILL, 0, 1'b1, '1);
    wait_done();

    // DRAIN from all ones: four shifts.
    issue(DRAIN, 4 * TICK, 1'b1, '0);
    wait_done();

    // RAIN with an intruding DRAIN start mid-run, which must be ignored.
    issue(RAIN, FRAMES * TICK, 1'b0, '0);
    repeat (6) @(negedge clk);
    start = 1'b1;
    mode  = DRAIN;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reserved mode from IDLE is ignored.
    @(negedge clk);
    start = 1'b1;
    mode  = RSVD;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // RAIN aborted by reset on edge N+13: no done ever follows.
    issue(RAIN, FRAMES * TICK, 1'b0, '0);
    while (edge_cnt < run_start + 12) @(negedge clk);
    reset  = 1'b1;
    run_on = 1'b0;
    exp_q.delete();
    cur_pat = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_rain_fx.md
MATRIX_RAIN_FX -- requirements
Module: matrix_rain_fx

Interface
REQ-001 SHALL have parameter ROWS, default 16, meaning number of display rows, range 2..16.
REQ-002 SHALL have parameter COLS, default 16, meaning number of display columns, range 2..16.
REQ-003 SHALL have parameter TICK_MAX, default 300, meaning clocks per animation step, minimum 2.
REQ-004 SHALL have parameter RAIN_FRAMES, default 64, meaning steps per RAIN run, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: request to begin a run.
REQ-008 SHALL have port mode, input, 2 bits: 00 RAIN, 01 FILL, 10 DRAIN, 11 reserved.
REQ-009 SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when a run completes.
REQ-011 SHALL have port pattern, output, [ROWS-1:0][COLS-1:0]: pattern[r][c] is the pixel at row r (0 = top), column c.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
- IDLE -> RUN on start=1 with mode!=11.
- RUN -> DONE when the completion condition holds after a shift.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 SHALL latch mode when start is accepted; mode changes during RUN SHALL have no effect.
REQ-014 SHALL ignore start while in RUN or DONE, and SHALL ignore start with mode=11; in both cases no state changes.
REQ-015 SHALL drive busy=1 exactly while in RUN, and done=1 exactly while in DONE.
REQ-016 SHALL run a step counter of width $clog2(TICK_MAX) only while in RUN; it clears to 0 on the accepted-start edge and wraps at TICK_MAX-1.
REQ-017 SHALL shift on each edge where the counter equals TICK_MAX-1.
- If start is accepted at edge N, shifts occur at edges N+k*TICK_MAX.
REQ-018 SHALL perform a shift as: row r takes row r-1 for r=1..ROWS-1; row 0, column c takes the spawn bit s[c]; row ROWS-1 content is discarded.
REQ-019 SHALL use a 16-bit Fibonacci LFSR with XNOR feedback (taps 16,15,13,4), seed 16'h0004 on reset, advancing every clock irrespective of state.
REQ-020 SHALL compute spawn bits from the LFSR value L sampled on the shift edge:
- RAIN: s[c] = L[c] AND L[(c+5) mod 16].
- FILL: s[c] = L[c] OR pattern[0][c].
- DRAIN: s[c] = 0.
REQ-021 SHALL complete a run on these conditions:
- RAIN: after RAIN_FRAMES shifts; the frame counter has width $clog2(RAIN_FRAMES+1).
- FILL: when the post-shift pattern is all ones.
- DRAIN: when the post-shift pattern is all zeros.
REQ-022 SHALL evaluate completion only on shift edges, so a DRAIN started on an empty pattern completes after exactly one shift.
REQ-023 SHALL hold pattern in IDLE and DONE; the last frame SHALL remain visible after a run.
REQ-024 SHALL drive pattern directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, when reset=1 on an edge, load state IDLE, pattern all zeros, busy=0, done=0, counters 0 and LFSR 16'h0004, regardless of state.
REQ-026 SHALL let reset take priority over start and over a coincident shift; a run aborted by reset SHALL NOT pulse done.

Structure
REQ-027 SHALL place the mode_t enum (RAIN, FILL, DRAIN, RSVD) and the state_t enum (IDLE, RUN, DONE) in shared package fx_pkg.
REQ-028 SHALL implement the LFSR as sub-module lfsr16 (ports clk, reset, value[15:0]), with the seed as a parameter.
REQ-029 SHALL implement ROWS, COLS, TICK_MAX and RAIN_FRAMES as module parameters; only the LFSR seed and taps are fixed in lfsr16.

Verification (ROWS=4, COLS=4, TICK_MAX=4, RAIN_FRAMES=10)
REQ-030 SHALL cover: reset high for 3 cycles -> pattern=0, busy=0, done=0, and LFSR=16'h0004 on the following cycle.
REQ-031 SHALL cover: start with FILL at edge N -> first shift at edge N+4; pattern rows only ever gain ones; done pulses for 1 cycle the cycle after the first all-ones shift; busy=0 during that done cycle.
REQ-032 SHALL cover: DRAIN from the all-ones result of REQ-031 -> exactly 4 shifts, done at edge N+16, pattern=0.
REQ-033 SHALL cover: RAIN -> done at edge N+40 and no earlier; every shift satisfies new row r == old row r-1.
REQ-034 SHALL cover: start with DRAIN during a RAIN run, and start with mode=11 from IDLE -> both ignored; the RAIN timing is unchanged, and busy stays 0 for mode=11.
REQ-035 SHALL cover: reset asserted at edge N+13 of a RAIN run -> next cycle IDLE, pattern=0, and no done pulse is ever emitted for that run.
